// File: rtl/timer_pkg.sv
// Shared types for the down_timer block.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DIV_MAX = 255;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every DIV enabled cycles and restarts
// its count whenever the enable drops.
module tick_gen
  import timer_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] r_cnt;

  // Tick is combinational so a pause or abort in the same cycle suppresses it.
  assign tick = en && (r_cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!nrst || !en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counter with prescaled ticks, pause, abort and auto-reload.
// Inputs resolve as abort > start > pause > tick each cycle.
module down_timer
  import timer_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic         reload,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         at_zero,
  output logic         done,
  output logic         busy
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_count;
  logic [N-1:0] w_count_nxt;
  logic         r_done;
  logic         w_done_nxt;
  logic         w_en;
  logic         w_tick;

  assign w_en = (r_state == RUN) && !pause && !abort && !start;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .nrst (nrst),
    .en   (w_en),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            if (load_val != '0) begin
              w_state_nxt = RUN;
              w_count_nxt = load_val;
            end else begin
              w_state_nxt = DONE;
              w_count_nxt = '0;
              w_done_nxt  = 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            w_state_nxt = PAUSED;
          end else if (w_tick) begin
            if (r_count > ONE) begin
              w_count_nxt = r_count - ONE;
            end else if (reload && (load_val != '0)) begin
              w_count_nxt = load_val;
              w_done_nxt  = 1'b1;
            end else begin
              // Expiry also covers a zero reload value; never wraps below 0.
              w_state_nxt = DONE;
              w_count_nxt = '0;
              w_done_nxt  = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  assign count   = r_count;
  assign at_zero = (r_count == '0);
  assign done    = r_done;
  assign busy    = (r_state == RUN) || (r_state == PAUSED);

endmodule
